// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding definitions: operation select, opcode fields and
// immediate limits, used by the encoder and by decoder-side tests.
package legv8_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_ORR   = 4'd3,
        OP_LDUR  = 4'd4,
        OP_STUR  = 4'd5,
        OP_ADDI  = 4'd6,
        OP_SUBI  = 4'd7,
        OP_CBZ   = 4'd8,
        OP_BCOND = 4'd9
    } enc_op_t;

    localparam logic [10:0] OPC_ADD   = 11'b10001011000;
    localparam logic [10:0] OPC_SUB   = 11'b11001011000;
    localparam logic [10:0] OPC_AND   = 11'b10001010000;
    localparam logic [10:0] OPC_ORR   = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
    localparam logic [10:0] OPC_STUR  = 11'b11111000000;
    localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI  = 10'b1101000100;
    localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
    localparam logic [7:0]  OPC_BCOND = 8'b01010100;

    localparam int D_IMM_MIN  = -256;
    localparam int D_IMM_MAX  = 255;
    localparam int I_IMM_MIN  = 0;
    localparam int I_IMM_MAX  = 4095;
    localparam int CB_IMM_MIN = -262144;
    localparam int CB_IMM_MAX = 262143;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_BAD_OP    = 2'b01;
    localparam logic [1:0] ERR_IMM_RANGE = 2'b10;

    function automatic logic imm_in_range(input logic signed [31:0] imm,
                                          input int lo, input int hi);
        return (imm >= lo) && (imm <= hi);
    endfunction

endpackage

// File: rtl/instr_format.sv
// Combinational LEGv8 field packer: builds the instruction word for one
// request and reports whether the op is known and the immediate fits.
module instr_format
    import legv8_pkg::*;
(
    input  logic [3:0]         op,
    input  logic [4:0]         rd,
    input  logic [4:0]         rn,
    input  logic [4:0]         rm,
    input  logic signed [31:0] imm,
    output logic [31:0]        word,
    output logic               legal,
    output logic               range_ok
);

    enc_op_t op_e;
    assign op_e = enc_op_t'(op);

    always_comb begin
        word     = '0;
        legal    = 1'b1;
        range_ok = 1'b1;
        case (op_e)
            OP_ADD:  word = {OPC_ADD, rm, 6'b000000, rn, rd};
            OP_SUB:  word = {OPC_SUB, rm, 6'b000000, rn, rd};
            OP_AND:  word = {OPC_AND, rm, 6'b000000, rn, rd};
            OP_ORR:  word = {OPC_ORR, rm, 6'b000000, rn, rd};
            OP_LDUR: begin
                word     = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
                range_ok = imm_in_range(imm, D_IMM_MIN, D_IMM_MAX);
            end
            OP_STUR: begin
                word     = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
                range_ok = imm_in_range(imm, D_IMM_MIN, D_IMM_MAX);
            end
            OP_ADDI: begin
                word     = {OPC_ADDI, imm[11:0], rn, rd};
                range_ok = imm_in_range(imm, I_IMM_MIN, I_IMM_MAX);
            end
            OP_SUBI: begin
                word     = {OPC_SUBI, imm[11:0], rn, rd};
                range_ok = imm_in_range(imm, I_IMM_MIN, I_IMM_MAX);
            end
            // For BCOND the rd field carries the condition code
            OP_CBZ: begin
                word     = {OPC_CBZ, imm[18:0], rd};
                range_ok = imm_in_range(imm, CB_IMM_MIN, CB_IMM_MAX);
            end
            OP_BCOND: begin
                word     = {OPC_BCOND, imm[18:0], rd};
                range_ok = imm_in_range(imm, CB_IMM_MIN, CB_IMM_MAX);
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder: one registered output stage with valid/ready
// handshake, an 8-bit word address counter and a sticky error flag.
module instr_encoder
    import legv8_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [7:0]  addr,
    output logic        err,
    output logic [1:0]  err_code
);

    logic signed [31:0] imm_s;
    logic [31:0]        word;
    logic               legal;
    logic               range_ok;
    logic               accept;
    logic               ok;

    logic               vld_p1;
    logic [31:0]        instr_p1;
    logic [7:0]         addr_p1;
    logic [7:0]         cnt;
    logic               err_q;
    logic [1:0]         err_code_q;

    assign imm_s = $signed(imm);

    instr_format u_format (
        .op       (op),
        .rd       (rd),
        .rn       (rn),
        .rm       (rm),
        .imm      (imm_s),
        .word     (word),
        .legal    (legal),
        .range_ok (range_ok)
    );

    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;
    assign ok       = legal && range_ok;

    // ---- stage p1: output register (illegal requests are consumed but drop the word)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            instr_p1   <= '0;
            addr_p1    <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            if (accept && ok) begin
                vld_p1   <= 1'b1;
                instr_p1 <= word;
                addr_p1  <= cnt;
                cnt      <= cnt + 8'd1;
            end else if (out_ready) begin
                vld_p1   <= 1'b0;
            end
            if (accept && !ok && !err_q) begin
                err_q      <= 1'b1;
                err_code_q <= legal ? ERR_IMM_RANGE : ERR_BAD_OP;
            end
        end
    end

    assign out_valid = vld_p1;
    assign instr     = instr_p1;
    assign addr      = addr_p1;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL use one clock and asynchronous active-high reset; ports listed clock and reset first.
REQ-002 SHALL have ports (name  direction  width  meaning):
  clk  in  1  clock, rising edge
  reset  in  1  async active-high reset
  in_valid  in  1  request valid
  in_ready  out  1  encoder can accept request
  op  in  4  operation select (enc_op_t)
  rd  in  5  Rd/Rt field
  rn  in  5  Rn field
  rm  in  5  Rm field (R-format only)
  imm  in  32  signed immediate / offset (two's complement)
  out_valid  out  1  encoded word valid
  out_ready  in  1  downstream accepts word
  instr  out  32  LEGv8 instruction word
  addr  out  8  imem word address of instr
  err  out  1  sticky illegal-request flag
  err_code  out  2  cause of first error: 01 bad op, 10 imm range

Function
REQ-003 SHALL encode op: ADD, SUB, AND, ORR (R); LDUR, STUR (D); ADDI, SUBI (I); CBZ, BCOND (CB); codes 0-9, 10-15 illegal.
REQ-004 SHALL use opcodes: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000, ADDI 1001000100, SUBI 1101000100, CBZ 10110100, BCOND 01010100.
REQ-005 SHALL place R fields: [31:21] opcode, [20:16] rm, [15:10] 000000, [9:5] rn, [4:0] rd.
REQ-006 SHALL place D fields: [31:21] opcode, [20:12] imm[8:0], [11:10] 00, [9:5] rn, [4:0] rd.
REQ-007 SHALL place I fields: [31:22] opcode, [21:10] imm[11:0], [9:5] rn, [4:0] rd.
REQ-008 SHALL place CB fields: [31:24] opcode, [23:5] imm[18:0], [4:0] rd (condition code for BCOND).
REQ-009 SHALL range-check imm: D -256..255, I 0..4095, CB -262144..262143; R ignores imm.
REQ-010 SHALL handshake: request accepted when in_valid && in_ready; word transferred when out_valid && out_ready.
REQ-011 SHALL drive in_ready = !out_valid || out_ready (one output register, full throughput).
REQ-012 SHALL register encoded word with latency 1: accepted request in cycle N gives out_valid in N+1.
REQ-013 SHALL hold instr and addr stable while out_valid && !out_ready.
REQ-014 SHALL accept (consume) illegal requests without producing a word; out_valid falls if a transfer coincides.
REQ-015 SHALL set err on first illegal request and latch err_code for that request; later errors do not change err_code.
REQ-016 SHALL use bad-op code when op illegal regardless of imm.
REQ-017 SHALL keep an 8-bit address counter, addr = counter value when word is loaded; counter increments only on legal accepted requests, wraps 255->0.
REQ-018 SHALL, on simultaneous transfer and accept, replace the output with the new word in same edge.

Reset
REQ-019 SHALL, on reset asserted (any time, including mid-transfer), clear out_valid, instr=0, addr=0, counter=0, err=0, err_code=00 asynchronously; in_ready=1 after reset.
REQ-020 SHALL discard any pending output word on reset; no partial word emitted.

Structure
REQ-021 SHALL define enc_op_t, opcode constants and imm range limits in shared package legv8_pkg, shared with decoder tests.
REQ-022 SHALL use one combinational sub-module instr_format (op, fields, imm -> word, legal, range_ok); rest handshake/counter logic.

Verification
REQ-023 ADD rd=1 rn=2 rm=3, out_ready=1 -> next cycle instr=0x8B030041, addr=0.
REQ-024 LDUR rd=5 rn=6 imm=-8 -> instr=0xF85F80C5; then STUR rd=5 rn=6 imm=8 -> 0xF80080C5, addr=1.
REQ-025 ADDI rd=0 rn=0 imm=4096 -> no out_valid, err=1, err_code=10; following op=12 leaves err_code=10.
REQ-026 out_ready=0 with 2 legal requests -> first word held, in_ready=0, second accepted only after out_ready=1.
REQ-027 256 legal CBZ rd=0 imm=1 -> addr sequence 0..255 then 0, instr=0xB4000020 each.
REQ-028 reset pulsed while out_valid=1 and out_ready=0 -> out_valid=0, addr counter 0, next word addr=0.
